// File: rtl/mmio_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : mmio_reg_bank
// Purpose  : picorv32 memory-mapped bank of byte-strobed output registers and
//            sampled input registers with optional write-1-to-clear sticky bits.
// Revision : 1.0  initial release
// ============================================================================
module mmio_reg_bank #(
  parameter logic [31:0]           BASE_ADDR      = 32'h1000_0000,
  parameter int                    NUM_OUT        = 4,
  parameter int                    NUM_IN         = 2,
  parameter logic [NUM_OUT*32-1:0] OUT_RESET      = '0,
  parameter logic [NUM_IN*32-1:0]  IN_STICKY_MASK = '0
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  logic                    mem_valid,
  input  logic                    mem_instr,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wstrb,
  output logic                    mem_ready,
  output logic [31:0]             mem_rdata,
  output logic [NUM_OUT*32-1:0]   regs_out,
  output logic [NUM_OUT-1:0]      wr_pulse_out,
  input  logic [NUM_IN*32-1:0]    regs_in
);

  localparam int c_TOTAL = NUM_OUT + NUM_IN;
  localparam int c_NIN   = (NUM_IN > 0) ? NUM_IN : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [29:0]             w_word_off;
  logic [4:0]              w_idx;
  logic                    w_hit;
  logic                    w_accept;
  logic                    w_write;
  logic [31:0]             w_byte_mask;
  logic [31:0]             w_rd_val;
  logic [NUM_OUT-1:0]      w_wr_out;
  logic [NUM_OUT*32-1:0]   r_out;
  logic [c_NIN*32-1:0]     r_in;
  logic [31:0]             r_rdata;
  logic [NUM_OUT-1:0]      r_wr_pulse;
  logic                    w_unused_addr_lsb;

  // Decode is done on word addresses; the byte offset within a word is ignored.
  assign w_unused_addr_lsb = ^mem_addr[1:0];
  assign w_word_off  = mem_addr[31:2] - BASE_ADDR[31:2];
  assign w_idx       = w_word_off[4:0];
  assign w_hit       = mem_valid & ~mem_instr
                     & (mem_addr[31:2] >= BASE_ADDR[31:2])
                     & (w_word_off < 30'(c_TOTAL));
  assign w_accept    = (r_state == ST_IDLE) & w_hit;
  assign w_write     = |mem_wstrb;
  assign w_byte_mask = {{8{mem_wstrb[3]}}, {8{mem_wstrb[2]}},
                        {8{mem_wstrb[1]}}, {8{mem_wstrb[0]}}};

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_hit) w_state_nxt = ST_ACK;
      ST_ACK:  w_state_nxt = ST_HOLD;
      ST_HOLD: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (w_idx == 5'(i)) w_rd_val = r_out[32*i +: 32];
    end
    for (int j = 0; j < NUM_IN; j++) begin
      if (w_idx == 5'(NUM_OUT + j)) w_rd_val = r_in[32*j +: 32];
    end
  end

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_wr
    assign w_wr_out[gi] = w_accept & w_write & (w_idx == 5'(gi));
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_out <= OUT_RESET;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (w_wr_out[i]) begin
          r_out[32*i +: 32] <= (r_out[32*i +: 32] & ~w_byte_mask)
                             | (mem_wdata & w_byte_mask);
        end
      end
    end
  end

  if (NUM_IN > 0) begin : g_in
    logic [NUM_IN*32-1:0] w_clr;

    always_comb begin
      w_clr = '0;
      for (int j = 0; j < NUM_IN; j++) begin
        if (w_accept && w_write && (w_idx == 5'(NUM_OUT + j))) begin
          w_clr[32*j +: 32] = mem_wdata & w_byte_mask;
        end
      end
    end

    // A new set arriving in the same cycle as a clear takes precedence.
    always_ff @(posedge clk_in) begin
      if (reset_in) begin
        r_in <= '0;
      end else begin
        r_in <= (r_in & ~w_clr & IN_STICKY_MASK) | regs_in;
      end
    end
  end else begin : g_no_in
    assign r_in = '0;
  end

  // Read data is captured pre-write so the ACK cycle returns the old contents.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_rdata    <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_rdata    <= w_accept ? w_rd_val : 32'h0;
      r_wr_pulse <= w_wr_out;
    end
  end

  assign mem_ready    = (r_state == ST_ACK);
  assign mem_rdata    = r_rdata;
  assign regs_out     = r_out;
  assign wr_pulse_out = r_wr_pulse;

endmodule
`default_nettype wire

// File: tb/tb_mmio_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_reg_bank
// Purpose  : Self-checking bench for mmio_reg_bank with a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_reg_bank;

  localparam logic [31:0]  c_BASE    = 32'h1000_0000;
  localparam logic [127:0] c_RST_VAL = 128'hCAFE0000_00000000_00000000_12345678;
  localparam logic [63:0]  c_STK     = 64'hFF000000_0000FFFF;

  logic         clk_in = 1'b0;
  logic         reset_in;
  logic         mem_valid;
  logic         mem_instr;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic [3:0]   mem_wstrb;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic [127:0] regs_out;
  logic [3:0]   wr_pulse_out;
  logic [63:0]  regs_in;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_out [4];
  logic [31:0] m_in  [2];
  int          m_phase;
  logic        exp_ready;
  logic [31:0] exp_rdata;
  logic [3:0]  exp_pulse;

  always #5 clk_in = ~clk_in;

  mmio_reg_bank #(
    .BASE_ADDR      (c_BASE),
    .NUM_OUT        (4),
    .NUM_IN         (2),
    .OUT_RESET      (c_RST_VAL),
    .IN_STICKY_MASK (c_STK)
  ) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .mem_valid    (mem_valid),
    .mem_instr    (mem_instr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wstrb    (mem_wstrb),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .regs_out     (regs_out),
    .wr_pulse_out (wr_pulse_out),
    .regs_in      (regs_in)
  );

  function automatic logic [127:0] m_pack();
    return {m_out[3], m_out[2], m_out[1], m_out[0]};
  endfunction

  // One clock: advance the model on the rising edge, return on the falling edge.
  task automatic tick();
    logic [31:0] mask;
    logic [31:0] clr [2];
    int          idx;
    @(posedge clk_in);
    clr[0] = '0;
    clr[1] = '0;
    if (reset_in) begin
      for (int i = 0; i < 4; i++) m_out[i] = c_RST_VAL[32*i +: 32];
      m_in[0] = '0;
      m_in[1] = '0;
      m_phase = 0;
      exp_rdata = '0;
      exp_pulse = '0;
    end else begin
      exp_rdata = '0;
      exp_pulse = '0;
      if (m_phase == 0 && mem_valid && !mem_instr && mem_addr >= c_BASE &&
          (mem_addr - c_BASE) / 4 < 6) begin
        idx = int'((mem_addr - c_BASE) / 4);
        exp_rdata = (idx < 4) ? m_out[idx] : m_in[idx-4];
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{mem_wstrb[b]}};
        if (mem_wstrb != 4'h0) begin
          if (idx < 4) begin
            m_out[idx] = (m_out[idx] & ~mask) | (mem_wdata & mask);
            exp_pulse[idx] = 1'b1;
          end else begin
            clr[idx-4] = mem_wdata & mask;
          end
        end
        m_phase = 1;
      end else begin
        m_phase = (m_phase == 1) ? 2 : 0;
      end
      for (int j = 0; j < 2; j++)
        m_in[j] = (m_in[j] & ~clr[j] & c_STK[32*j +: 32]) | regs_in[32*j +: 32];
    end
    exp_ready = (m_phase == 1);
    @(negedge clk_in);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic ins);
    mem_valid = 1'b1;
    mem_instr = ins;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
  endtask

  task automatic idle_bus();
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic do_access(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic rdy,
                           output logic [31:0] rd, output logic [31:0] erd);
    drive(a, d, s, 1'b0);
    tick();
    rdy = mem_ready;
    rd  = mem_rdata;
    erd = exp_rdata;
    idle_bus();
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_in = 1'b1;
    idle_bus();
    regs_in = '0;
    tick();
    tick();
    reset_in = 1'b0;
    n_checks++;
    if (regs_out !== c_RST_VAL) begin
      n_fail++;
      $display("FAIL reset_regs_out: got %h expected %h", regs_out, c_RST_VAL);
    end
    n_checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || wr_pulse_out !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b rdata=%h pulse=%b expected 0/0/0",
               mem_ready, mem_rdata, wr_pulse_out);
    end
    drive(32'h1000_000C, 32'h0, 4'h0, 1'b0);
    tick();
    n_checks++;
    if (mem_ready !== 1'b1 || mem_rdata !== 32'hCAFE_0000) begin
      n_fail++;
      $display("FAIL read_reg3_ack: ready=%b rdata=%h expected 1/cafe0000",
               mem_ready, mem_rdata);
    end
    idle_bus();
    tick();
    n_checks++;
    if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL read_reg3_after: ready=%b rdata=%h expected 0/0",
               mem_ready, mem_rdata);
    end
    tick();
  endtask

  task automatic test_write_strobe();
    drive(32'h1000_0004, 32'hAABB_CCDD, 4'b0101, 1'b0);
    tick();
    n_checks++;
    if (mem_ready !== 1'b1 || regs_out[63:32] !== 32'h00BB_00DD) begin
      n_fail++;
      $display("FAIL strobe_write: ready=%b reg1=%h expected 1/00bb00dd",
               mem_ready, regs_out[63:32]);
    end
    n_checks++;
    if (wr_pulse_out !== 4'b0010 || mem_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL strobe_pulse: pulse=%b rdata=%h expected 0010/0",
               wr_pulse_out, mem_rdata);
    end
    idle_bus();
    tick();
    n_checks++;
    if (wr_pulse_out !== 4'h0 || mem_rdata !== 32'h0 || mem_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL strobe_after: pulse=%b rdata=%h ready=%b expected 0/0/0",
               wr_pulse_out, mem_rdata, mem_ready);
    end
    tick();
  endtask

  task automatic test_sticky();
    logic        rdy;
    logic [31:0] rd, erd;
    regs_in = 64'h1;
    tick();
    regs_in = '0;
    tick();
    for (int k = 0; k < 2; k++) begin
      do_access(32'h1000_0010, 32'h0, 4'h0, rdy, rd, erd);
      n_checks++;
      if (rdy !== 1'b1 || rd !== 32'h1 || rd !== erd) begin
        n_fail++;
        $display("FAIL sticky_hold read %0d: ready=%b rdata=%h expected 1/00000001",
                 k, rdy, rd);
      end
    end
    do_access(32'h1000_0010, 32'h1, 4'b0001, rdy, rd, erd);
    do_access(32'h1000_0010, 32'h0, 4'h0, rdy, rd, erd);
    n_checks++;
    if (rdy !== 1'b1 || rd !== 32'h0) begin
      n_fail++;
      $display("FAIL sticky_w1c: ready=%b rdata=%h expected 1/00000000", rdy, rd);
    end
    regs_in = 64'h1;
    tick();
    do_access(32'h1000_0010, 32'h1, 4'b0001, rdy, rd, erd);
    do_access(32'h1000_0010, 32'h0, 4'h0, rdy, rd, erd);
    n_checks++;
    if (rd[0] !== 1'b1 || rd !== erd) begin
      n_fail++;
      $display("FAIL sticky_set_wins: rdata=%h expected %h", rd, erd);
    end
    regs_in = '0;
    tick();
  endtask

  task automatic test_ignored();
    logic [127:0] saved;
    logic [31:0]  addrs [3];
    logic         seen;
    addrs[0] = 32'h1000_0000;
    addrs[1] = 32'h1000_0018;
    addrs[2] = 32'h0FFF_FFFC;
    saved = regs_out;
    for (int k = 0; k < 3; k++) begin
      seen = 1'b0;
      drive(addrs[k], 32'hFFFF_FFFF, 4'hF, (k == 0));
      for (int c = 0; c < 4; c++) begin
        tick();
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin
        n_fail++;
        $display("FAIL ignored_access %h: ready=%b rdata=%h expected 0/0",
                 addrs[k], mem_ready, mem_rdata);
      end
    end
    idle_bus();
    tick();
    n_checks++;
    if (regs_out !== saved || regs_out !== m_pack()) begin
      n_fail++;
      $display("FAIL ignored_regs: got %h expected %h", regs_out, saved);
    end
  endtask

  task automatic test_back_to_back();
    int n_rdy;
    int last;
    int min_gap;
    n_rdy = 0;
    last = -10;
    min_gap = 100;
    drive(32'h1000_0008, 32'h1357_9BDF, 4'hF, 1'b0);
    for (int c = 0; c < 9; c++) begin
      tick();
      n_checks++;
      if (mem_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL b2b_ready cycle %0d: got %b expected %b", c, mem_ready, exp_ready);
      end
      if (mem_ready === 1'b1) begin
        if (c - last < min_gap) min_gap = c - last;
        last = c;
        n_rdy++;
      end
    end
    n_checks++;
    if (n_rdy != 3 || min_gap != 3) begin
      n_fail++;
      $display("FAIL b2b_count: readies=%0d gap=%0d expected 3/3", n_rdy, min_gap);
    end
    idle_bus();
    tick();
    tick();
    drive(32'h1000_0008, 32'h0000_0055, 4'hF, 1'b0);
    tick();
    n_checks++;
    if (mem_ready !== 1'b1 || regs_out[95:64] !== 32'h55) begin
      n_fail++;
      $display("FAIL rst_ack_pre: ready=%b reg2=%h expected 1/00000055",
               mem_ready, regs_out[95:64]);
    end
    reset_in = 1'b1;
    idle_bus();
    tick();
    n_checks++;
    if (mem_ready !== 1'b0 || regs_out !== c_RST_VAL || mem_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_in_ack: ready=%b regs=%h expected 0/%h",
               mem_ready, regs_out, c_RST_VAL);
    end
    reset_in = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      regs_in = {$urandom & $urandom & $urandom, $urandom & $urandom & $urandom};
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 3) == 0) begin
          idle_bus();
        end else begin
          drive(c_BASE - 32'd8 + 32'(4 * $urandom_range(0, 9)) + 32'($urandom_range(0, 3)),
                $urandom,
                ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0,
                ($urandom_range(0, 9) == 0));
        end
      end
      tick();
      n_checks++;
      if (mem_ready !== exp_ready || mem_rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL rand_bus cycle %0d: ready=%b rdata=%h expected %b/%h",
                 c, mem_ready, mem_rdata, exp_ready, exp_rdata);
      end
      n_checks++;
      if (wr_pulse_out !== exp_pulse || regs_out !== m_pack()) begin
        n_fail++;
        $display("FAIL rand_regs cycle %0d: pulse=%b regs=%h expected %b/%h",
                 c, wr_pulse_out, regs_out, exp_pulse, m_pack());
      end
    end
    idle_bus();
    regs_in = '0;
    tick();
    tick();
  endtask

  initial begin
    reset_in  = 1'b1;
    mem_valid = 1'b0;
    mem_instr = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    regs_in   = '0;
    test_reset();
    test_write_strobe();
    test_sticky();
    test_ignored();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
